// File: rtl/pb_conditioner_if.sv
// Push-button port bundle: raw buttons and event-clear strobe in, conditioned levels,
// press pulses and sticky event flags out.
interface pb_conditioner_if #(
  parameter int N_PBs = 3
);
  logic [N_PBs-1:0] PB_RAW;
  logic [N_PBs-1:0] PB_CLEAN;
  logic [N_PBs-1:0] PB_PRESS;
  logic [N_PBs-1:0] PB_EVENT;
  logic             EVT_CLR;
  logic [N_PBs-1:0] EVT_CLR_MASK;
  logic             EVT_ANY;

  modport master (
    output PB_RAW, EVT_CLR, EVT_CLR_MASK,
    input  PB_CLEAN, PB_PRESS, PB_EVENT, EVT_ANY
  );

  modport slave (
    input  PB_RAW, EVT_CLR, EVT_CLR_MASK,
    output PB_CLEAN, PB_PRESS, PB_EVENT, EVT_ANY
  );
endinterface

// File: rtl/pb_conditioner.sv
// Push-button synchroniser/debouncer with one-cycle press pulses and sticky W1C event flags.
// Define PB_AUTOREPEAT_EN to build the hold-to-repeat pulse generator.
module pb_conditioner #(
  parameter int N_PBs           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  pb_conditioner_if.slave   pb_bus
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef PB_AUTOREPEAT_EN
  localparam int            RW         = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);
`else
  wire w_unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  wire [N_PBs-1:0] w_clean;
  wire [N_PBs-1:0] w_press;
  wire [N_PBs-1:0] w_event;

  generate
    for (genvar gi = 0; gi < N_PBs; gi++) begin : g_pb
      logic          r_sync1, r_sync2;
      state_t        r_state, w_state_next;
      logic [CW-1:0] r_cnt, w_cnt_next;
      logic          r_clean, w_clean_next;
      logic          r_press, w_press_next;
      logic          r_event, w_event_next;
      logic          w_clr;
`ifdef PB_AUTOREPEAT_EN
      logic [RW-1:0] r_rep, w_rep_next;
`endif

      assign w_clr = pb_bus.EVT_CLR & pb_bus.EVT_CLR_MASK[gi];

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_state <= LOW;
          r_cnt   <= '0;
          r_clean <= 1'b0;
          r_press <= 1'b0;
          r_event <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
          r_rep   <= '0;
`endif
        end else begin
          r_sync1 <= pb_bus.PB_RAW[gi];
          r_sync2 <= r_sync1;
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
          r_clean <= w_clean_next;
          r_press <= w_press_next;
          r_event <= w_event_next;
`ifdef PB_AUTOREPEAT_EN
          r_rep   <= w_rep_next;
`endif
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clean_next = r_clean;
        w_press_next = 1'b0;
`ifdef PB_AUTOREPEAT_EN
        w_rep_next   = '0;
`endif
        case (r_state)
          LOW: if (r_sync2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_next = HIGH;
              w_clean_next = 1'b1;
              w_press_next = 1'b1;
            end else begin
              w_state_next = WAIT_HIGH;
              w_cnt_next   = CNT_ONE;
            end
          end
          WAIT_HIGH: begin
            if (!r_sync2) begin
              w_state_next = LOW;
              w_cnt_next   = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_state_next = HIGH;
              w_cnt_next   = '0;
              w_clean_next = 1'b1;
              w_press_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
          HIGH: if (!r_sync2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_next = LOW;
              w_clean_next = 1'b0;
            end else begin
              w_state_next = WAIT_LOW;
              w_cnt_next   = CNT_ONE;
            end
          end
          WAIT_LOW: begin
            if (r_sync2) begin
              w_state_next = HIGH;
              w_cnt_next   = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_state_next = LOW;
              w_cnt_next   = '0;
              w_clean_next = 1'b0;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
          default: w_state_next = LOW;
        endcase
`ifdef PB_AUTOREPEAT_EN
        // Repeat timer restarts on every entry into HIGH and is idle elsewhere.
        if (w_state_next == HIGH) begin
          if (r_state != HIGH) begin
            w_rep_next = REP_ONE;
          end else if (r_rep == REP_FIRE) begin
            w_press_next = 1'b1;
            w_rep_next   = REP_RELOAD;
          end else begin
            w_rep_next = r_rep + REP_ONE;
          end
        end
`endif
        // A pulse being raised or currently high overrides a same-cycle clear.
        w_event_next = (r_event & ~w_clr) | w_press_next | r_press;
      end

      assign w_clean[gi] = r_clean;
      assign w_press[gi] = r_press;
      assign w_event[gi] = r_event;
    end
  endgenerate

  assign pb_bus.PB_CLEAN = w_clean;
  assign pb_bus.PB_PRESS = w_press;
  assign pb_bus.PB_EVENT = w_event;
  assign pb_bus.EVT_ANY  = |w_event;
endmodule
